universal_shift_register: RTL and testbench

- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register bank with per-cycle mode select (hold, shift right, shift left, parallel load), true and complement outputs, and serial in/out at both ends.
- Tracks how many shifts have occurred since the last load and pulses a word-complete flag after WIDTH shifts.
- Used as the serialiser/deserialiser and general storage element in the datapath.

---
 rtl/universal_shift_register.sv | 112 +++++++++++
 tb/tb_universal_shift_register.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// universal_shift_register
//   WIDTH-bit register bank with per-cycle mode select: hold, shift right,
//   shift left or parallel load. It provides true and complement outputs and
//   serial in/out at both ends. It counts shifts since the last load or reset,
//   and word_done pulses for one cycle after every WIDTH-th shift.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous reset, active-high (priority over en and mode)
//   en        clock enable; 0 holds q and shift_cnt
//   mode      00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d         parallel load data (mode 11 only)
//   sin_r     serial input entering the MSB on shift right
//   sin_l     serial input entering the LSB on shift left
//   q         register contents
//   ql        bitwise complement of q
//   sout_r    q[0], the bit leaving on shift right
//   sout_l    q[WIDTH-1], the bit leaving on shift left
//   shift_cnt shifts since last load/reset, modulo WIDTH
//   word_done one-cycle pulse after a full word has been shifted
module universal_shift_register #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
  parameter int                 CNT_W       = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] ql,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             word_done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             shifting;

  always_comb begin
    data_d   = data_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    shifting = 1'b0;
    if (en) begin
      case (mode)
        MODE_RIGHT: begin
          data_d   = {sin_r, data_q[WIDTH-1:1]};
          shifting = 1'b1;
        end
        MODE_LEFT: begin
          data_d   = {data_q[WIDTH-2:0], sin_l};
          shifting = 1'b1;
        end
        MODE_LOAD: begin
          data_d = d;
          cnt_d  = '0;
        end
        MODE_HOLD: begin
          data_d = data_q;
        end
        default: begin
          data_d = data_q;
        end
      endcase
      // Both shift directions share the counter; the wrap at WIDTH-1 keeps
      // the count modulo WIDTH even when WIDTH is not a power of two.
      if (shifting) begin
        if (cnt_q == CNT_LAST) begin
          cnt_d  = '0;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= RESET_VALUE;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q         = data_q;
  assign ql        = ~data_q;
  assign sout_r    = data_q[0];
  assign sout_l    = data_q[WIDTH-1];
  assign shift_cnt = cnt_q;
  assign word_done = done_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Testbench for universal_shift_register (WIDTH=8, RESET_VALUE=0).
// A behavioural model tracks the expected register value, the shift count
// and the word_done pulse. Directed scenarios check fixed constants, and a
// random phase checks every output against the model.
module tb_universal_shift_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, en, sin_r, sin_l;
  logic [1:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q, ql;
  logic         sout_r, sout_l, word_done;
  logic [2:0]   shift_cnt;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int m_q    = 0;
  int m_cnt  = 0;
  int m_done = 0;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .q(q), .ql(ql),
    .sout_r(sout_r), .sout_l(sout_l),
    .shift_cnt(shift_cnt), .word_done(word_done)
  );

  always #5 clk = ~clk;

  // Apply one set of inputs for one rising edge. Update the model from the
  // behavioural rules. Sampling happens 1 time unit after the edge.
  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic [W-1:0] dd, input logic sr, input logic sl);
    rst = r; en = e; mode = md; d = dd; sin_r = sr; sin_l = sl;
    @(posedge clk);
    if (r) begin
      m_q = 0; m_cnt = 0; m_done = 0;
    end else if (!e || md == 2'd0) begin
      m_done = 0;
    end else if (md == 2'd3) begin
      m_q = int'(dd); m_cnt = 0; m_done = 0;
    end else begin
      if (md == 2'd1) m_q = (m_q / 2) + (sr ? 128 : 0);
      else            m_q = ((m_q * 2) % 256) + (sl ? 1 : 0);
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin m_cnt = 0; m_done = 1; end
      else m_done = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 2'b11, 8'hFF, 1'b1, 1'b1);
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (ql !== 8'hFF) begin failures++; $display("FAIL reset_ql got=%h exp=ff", ql); end
    checks++; if (shift_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", shift_cnt); end
    checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", word_done); end
  endtask

  task automatic test_load_hold();
    step(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL load_q got=%h exp=a5", q); end
    checks++; if (ql !== 8'h5A) begin failures++; $display("FAIL load_ql got=%h exp=5a", ql); end
    checks++; if (sout_l !== 1'b1 || sout_r !== 1'b1) begin failures++; $display("FAIL load_sout got=%b%b exp=11", sout_l, sout_r); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 2'b00, 8'h3C, 1'b1, 1'b1);
      checks++; if (q !== 8'hA5 || shift_cnt !== 3'd0) begin failures++; $display("FAIL hold_%0d got q=%h cnt=%0d exp q=a5 cnt=0", i, q, shift_cnt); end
    end
    step(1'b0, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0);
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL en_low_q got=%h exp=a5", q); end
  endtask

  task automatic test_serialise_right();
    logic [7:0] exp_bits;
    int pulses;
    exp_bits = 8'b1010_0101;   // sout_r sequence 1,0,1,0,0,1,0,1 = LSB first of A5
    pulses = 0;
    step(1'b0, 1'b1, 2'b11, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++; if (sout_r !== exp_bits[i]) begin failures++; $display("FAIL ser_sout_r_%0d got=%b exp=%b", i, sout_r, exp_bits[i]); end
      step(1'b0, 1'b1, 2'b01, 8'hFF, 1'b0, 1'b1);
      if (word_done === 1'b1) pulses++;
    end
    checks++; if (q !== 8'h00 || shift_cnt !== 3'd0) begin failures++; $display("FAIL ser_end got q=%h cnt=%0d exp q=00 cnt=0", q, shift_cnt); end
    checks++; if (word_done !== 1'b1 || pulses != 1) begin failures++; $display("FAIL ser_done got=%b pulses=%0d exp=1 pulses=1", word_done, pulses); end
    step(1'b0, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0);
    checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL ser_done_single got=%b exp=0", word_done); end
  endtask

  task automatic test_deserialise_left();
    logic [7:0] bits;
    bits = 8'b0101_0011;       // sin_l sequence 1,1,0,0,1,0,1,0 taken LSB first
    step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 2'b10, 8'hFF, 1'b1, bits[i]);
      checks++; if (shift_cnt !== 3'((i + 1) % 8)) begin failures++; $display("FAIL deser_cnt_%0d got=%0d exp=%0d", i, shift_cnt, (i + 1) % 8); end
      checks++; if (word_done !== (i == 7)) begin failures++; $display("FAIL deser_done_%0d got=%b exp=%b", i, word_done, (i == 7)); end
    end
    checks++; if (q !== 8'hCA) begin failures++; $display("FAIL deser_q got=%h exp=ca", q); end
    checks++; if (sout_l !== 1'b1 || sout_r !== 1'b0) begin failures++; $display("FAIL deser_sout got=%b%b exp=10", sout_l, sout_r); end
  endtask

  task automatic test_count_interrupt();
    int pulses;
    step(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0); if (word_done) pulses++; end
    for (int i = 0; i < 2; i++) begin step(1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 1'b0); if (word_done) pulses++; end
    checks++; if (shift_cnt !== 3'd5) begin failures++; $display("FAIL intr_en_cnt got=%0d exp=5", shift_cnt); end
    for (int i = 0; i < 2; i++) begin step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1); if (word_done) pulses++; end
    checks++; if (pulses != 0) begin failures++; $display("FAIL intr_early_pulse got=%0d exp=0", pulses); end
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
    checks++; if (word_done !== 1'b1 || shift_cnt !== 3'd0) begin failures++; $display("FAIL intr_done got=%b cnt=%0d exp=1 cnt=0", word_done, shift_cnt); end
    // load after 5 shifts restarts the count
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
    checks++; if (shift_cnt !== 3'd0 || word_done !== 1'b0 || q !== 8'h81) begin failures++; $display("FAIL intr_load got cnt=%0d done=%b q=%h exp cnt=0 done=0 q=81", shift_cnt, word_done, q); end
    pulses = 0;
    for (int i = 0; i < 7; i++) begin step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0); if (word_done) pulses++; end
    checks++; if (pulses != 0) begin failures++; $display("FAIL intr_load_early got=%0d exp=0", pulses); end
    step(1'b0, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
    checks++; if (word_done !== 1'b1) begin failures++; $display("FAIL intr_load_done got=%b exp=1", word_done); end
  endtask

  task automatic test_reset_mid_word();
    int pulses;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b1);
    checks++; if (q !== 8'h00 || shift_cnt !== 3'd0 || word_done !== 1'b0) begin failures++; $display("FAIL midrst got q=%h cnt=%0d done=%b exp q=00 cnt=0 done=0", q, shift_cnt, word_done); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin step(1'b0, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0); if (word_done) pulses++; end
    checks++; if (pulses != 1 || word_done !== 1'b1) begin failures++; $display("FAIL midrst_pulses got=%0d last=%b exp=1 last=1", pulses, word_done); end
  endtask

  task automatic test_random();
    logic r, e, sr, sl;
    logic [1:0] md;
    logic [W-1:0] dd;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 29) == 0);
      e  = ($urandom_range(0, 5) != 0);
      md = 2'($urandom_range(0, 3));
      dd = 8'($urandom);
      sr = 1'($urandom);
      sl = 1'($urandom);
      step(r, e, md, dd, sr, sl);
      checks++;
      if (q !== 8'(m_q) || ql !== ~8'(m_q) || sout_r !== 1'(m_q % 2) || sout_l !== 1'(m_q / 128)
          || shift_cnt !== 3'(m_cnt) || word_done !== 1'(m_done)) begin
        failures++;
        $display("FAIL rand_%0d got q=%h ql=%h sr=%b sl=%b cnt=%0d done=%b exp q=%h cnt=%0d done=%0d",
                 i, q, ql, sout_r, sout_l, shift_cnt, word_done, 8'(m_q), m_cnt, m_done);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; d = '0; sin_r = 1'b0; sin_l = 1'b0;
    #2;
    test_reset();
    test_load_hold();
    test_serialise_right();
    test_deserialise_left();
    test_count_interrupt();
    test_reset_mid_word();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
